// File: rtl/daq_pkg.sv
// Shared types and helpers for the DAQ capture path.
//   state_e         : capture FSM state encoding (matches out_state)
//   trig_e          : trigger mode encoding (reserved mode behaves as software)
//   SLOT_WIDTH      : width of one packed sample slot
//   frames_per_word : how many whole frames fit in one output word
package daq_pkg;

    localparam int SLOT_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ARMED   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        TRIG_SW    = 2'b00,
        TRIG_LEVEL = 2'b01,
        TRIG_IMM   = 2'b10,
        TRIG_RSVD  = 2'b11
    } trig_e;

    function automatic int frames_per_word(input int axis_w, input int channels);
        return axis_w / (SLOT_WIDTH * channels);
    endfunction

endpackage

// File: rtl/axis_skid_buffer_2.sv
// Two-entry output buffer with AXI-Stream style read side.
//   clk_i, rst_ni         : clock, async active-low reset
//   s_data_i/s_last_i     : word to store, written when s_valid_i and not full
//   m_data_o/m_last_o     : head word, held stable until m_valid_o && m_ready_i
//   full_o/empty_o        : occupancy flags; the writer drops on full
module axis_skid_buffer_2 #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    input  logic              s_valid_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              full_o,
    output logic              empty_o
);

    logic [DATA_W:0] mem_q [2];
    logic            wr_ptr_q;
    logic            rd_ptr_q;
    logic [1:0]      cnt_q;
    logic            push;
    logic            pop;

    assign full_o    = (cnt_q == 2'd2);
    assign empty_o   = (cnt_q == 2'd0);
    assign push      = s_valid_i && !full_o;
    assign pop       = !empty_o && m_ready_i;
    assign m_valid_o = !empty_o;
    assign {m_last_o, m_data_o} = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {s_last_i, s_data_i};
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) rd_ptr_q <= !rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/daq_capture_packer.sv
// Triggered multi-lane ADC capture and packer.
//   in_data/in_data_valid      : flattened ADC lanes (ch0 in LSBs) and strobe
//   in_pattern_en              : counter test pattern instead of ADC data
//   in_decim/in_capture_len    : keep 1 of N frames; frames per capture (0 = run)
//   in_trig_*/in_arm/in_abort  : trigger setup and control pulses
//   out_data/out_valid/in_ready/out_last : packed word stream
//   out_state/out_overflow/out_drop_cnt/out_frames : status
// Mode inputs are latched on arm and held for the whole capture.
module daq_capture_packer
    import daq_pkg::*;
#(
    parameter int INT_CHANNELS        = 2,
    parameter int INT_SAMPLE_WIDTH    = 10,
    parameter int INT_SIGNED          = 1,
    parameter int INT_AXIS_DATA_WIDTH = 32,
    parameter int INT_LEN_WIDTH       = 16,
    parameter int INT_DECIM_WIDTH     = 16
) (
    input  logic                                     in_clk,
    input  logic                                     in_rst_n,
    input  logic [INT_CHANNELS*INT_SAMPLE_WIDTH-1:0] in_data,
    input  logic                                     in_data_valid,
    input  logic                                     in_pattern_en,
    input  logic [INT_DECIM_WIDTH-1:0]               in_decim,
    input  logic [INT_LEN_WIDTH-1:0]                 in_capture_len,
    input  logic [1:0]                               in_trig_mode,
    input  logic [1:0]                               in_trig_ch,
    input  logic [INT_SAMPLE_WIDTH-1:0]              in_trig_level,
    input  logic                                     in_arm,
    input  logic                                     in_trig_sw,
    input  logic                                     in_abort,
    output logic [INT_AXIS_DATA_WIDTH-1:0]           out_data,
    output logic                                     out_valid,
    input  logic                                     in_ready,
    output logic                                     out_last,
    output logic [1:0]                               out_state,
    output logic                                     out_overflow,
    output logic [15:0]                              out_drop_cnt,
    output logic [INT_LEN_WIDTH-1:0]                 out_frames
);

    localparam int CH      = INT_CHANNELS;
    localparam int SW      = INT_SAMPLE_WIDTH;
    localparam int FRAME_W = SLOT_WIDTH * CH;
    localparam int FPW     = frames_per_word(INT_AXIS_DATA_WIDTH, INT_CHANNELS);
    localparam int FIDX_W  = (FPW > 1) ? $clog2(FPW) : 1;

    if (FPW < 1 || (INT_AXIS_DATA_WIDTH % FRAME_W) != 0) begin : g_bad_width
        $error("INT_AXIS_DATA_WIDTH must be a nonzero multiple of 16*INT_CHANNELS");
    end

    // latched configuration
    logic                       cfg_pat_q;
    logic [INT_DECIM_WIDTH-1:0] cfg_decim_q;
    logic [INT_LEN_WIDTH-1:0]   cfg_len_q;
    trig_e                      cfg_mode_q;
    logic [1:0]                 cfg_ch_q;
    logic [SW-1:0]              cfg_level_q;

    state_e                         state_q;
    logic [SW-1:0]                  base_q;
    logic [CH*SW-1:0]               s1_data_q;
    logic                           s1_vld_q;
    logic [SW-1:0]                  prev_q;
    logic                           prev_vld_q;
    logic [INT_DECIM_WIDTH-1:0]     dcnt_q;
    logic [INT_LEN_WIDTH-1:0]       frames_q;
    logic [INT_AXIS_DATA_WIDTH-1:0] acc_q;
    logic [FIDX_W-1:0]              fidx_q;
    logic [INT_AXIS_DATA_WIDTH-1:0] word_q;
    logic                           word_last_q;
    logic                           word_vld_q;
    logic                           overflow_q;
    logic [15:0]                    drop_q;

    logic [CH*SW-1:0]               pat;
    logic [FRAME_W-1:0]             frame_ext;
    logic [INT_AXIS_DATA_WIDTH-1:0] acc_d;
    logic [1:0]                     tch_sel;
    logic [SW-1:0]                  cur_smp;
    logic                           level_hit, trig, cap_active, accept, is_last, word_done;
    logic [INT_DECIM_WIDTH-1:0]     decim_max, dcnt_cur;
    logic [INT_LEN_WIDTH-1:0]       frames_d;
    logic                           buf_full, buf_empty, drop;

    function automatic logic [SLOT_WIDTH-1:0] ext(input logic [SW-1:0] s);
        logic [SLOT_WIDTH-1:0] r;
        logic                  sgn;
        sgn       = (INT_SIGNED != 0) && s[SW-1];
        r         = {SLOT_WIDTH{sgn}};
        r[SW-1:0] = s;
        return r;
    endfunction

    function automatic logic ge(input logic [SW-1:0] a, input logic [SW-1:0] b);
        if (INT_SIGNED != 0) return $signed(a) >= $signed(b);
        else                 return a >= b;
    endfunction

    always_comb begin
        pat       = '0;
        frame_ext = '0;
        for (int c = 0; c < CH; c++) begin
            pat[c*SW +: SW]                     = base_q + SW'(c);
            frame_ext[c*SLOT_WIDTH +: SLOT_WIDTH] = ext(s1_data_q[c*SW +: SW]);
        end
    end

    assign tch_sel   = (int'(cfg_ch_q) < CH) ? cfg_ch_q : 2'd0;
    assign cur_smp   = s1_data_q[tch_sel*SW +: SW];
    assign level_hit = s1_vld_q && prev_vld_q && !ge(prev_q, cfg_level_q) && ge(cur_smp, cfg_level_q);

    always_comb begin
        case (cfg_mode_q)
            TRIG_LEVEL: trig = level_hit;
            TRIG_IMM:   trig = s1_vld_q;
            default:    trig = in_trig_sw;
        endcase
    end

    // The trigger frame itself is the first captured frame, so in ARMED the
    // decimation counter is treated as already reset.
    assign decim_max  = (cfg_decim_q > INT_DECIM_WIDTH'(1)) ? cfg_decim_q - 1'b1 : '0;
    assign dcnt_cur   = (state_q == ST_ARMED) ? '0 : dcnt_q;
    assign cap_active = (state_q == ST_CAPTURE) || (state_q == ST_ARMED && trig);
    assign accept     = cap_active && s1_vld_q && (dcnt_cur == '0);
    assign frames_d   = frames_q + 1'b1;
    assign is_last    = accept && (cfg_len_q != '0) && (frames_d == cfg_len_q);
    assign word_done  = accept && (is_last || fidx_q == FIDX_W'(FPW - 1));
    assign drop       = word_vld_q && buf_full;

    always_comb begin
        acc_d = acc_q;
        acc_d[fidx_q*FRAME_W +: FRAME_W] = frame_ext;
    end

    // input stage and pattern generator
    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            base_q    <= '0;
            s1_data_q <= '0;
            s1_vld_q  <= 1'b0;
        end else begin
            s1_vld_q <= in_data_valid;
            if (in_data_valid) begin
                base_q    <= base_q + 1'b1;
                s1_data_q <= cfg_pat_q ? pat : in_data;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            state_q     <= ST_IDLE;
            cfg_pat_q   <= 1'b0;
            cfg_decim_q <= '0;
            cfg_len_q   <= '0;
            cfg_mode_q  <= TRIG_SW;
            cfg_ch_q    <= '0;
            cfg_level_q <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            dcnt_q      <= '0;
            frames_q    <= '0;
            acc_q       <= '0;
            fidx_q      <= '0;
            word_q      <= '0;
            word_last_q <= 1'b0;
            word_vld_q  <= 1'b0;
            overflow_q  <= 1'b0;
            drop_q      <= '0;
        end else begin
            word_vld_q <= 1'b0;
            if (s1_vld_q) begin
                prev_q     <= cur_smp;
                prev_vld_q <= 1'b1;
            end
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_q != 16'hFFFF) drop_q <= drop_q + 1'b1;
            end
            if (in_abort) begin
                state_q <= ST_IDLE;
                acc_q   <= '0;
                fidx_q  <= '0;
            end else begin
                case (state_q)
                    ST_IDLE: if (in_arm) begin
                        state_q     <= ST_ARMED;
                        cfg_pat_q   <= in_pattern_en;
                        cfg_decim_q <= in_decim;
                        cfg_len_q   <= in_capture_len;
                        cfg_mode_q  <= trig_e'(in_trig_mode);
                        cfg_ch_q    <= in_trig_ch;
                        cfg_level_q <= in_trig_level;
                        prev_vld_q  <= 1'b0;
                        overflow_q  <= 1'b0;
                        drop_q      <= '0;
                        frames_q    <= '0;
                    end
                    ST_ARMED: if (trig) begin
                        state_q <= ST_CAPTURE;
                        dcnt_q  <= '0;
                    end
                    ST_CAPTURE: begin end
                    // the final word may still sit in word_q on its way to the buffer
                    ST_DONE: if (buf_empty && !word_vld_q) state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
                if (cap_active && s1_vld_q)
                    dcnt_q <= (dcnt_cur == decim_max) ? '0 : dcnt_cur + 1'b1;
                if (accept) begin
                    frames_q <= frames_d;
                    if (word_done) begin
                        word_q      <= acc_d;
                        word_last_q <= is_last;
                        word_vld_q  <= 1'b1;
                        acc_q       <= '0;
                        fidx_q      <= '0;
                    end else begin
                        acc_q  <= acc_d;
                        fidx_q <= fidx_q + 1'b1;
                    end
                    if (is_last) state_q <= ST_DONE;
                end
            end
        end
    end

    axis_skid_buffer_2 #(.DATA_W(INT_AXIS_DATA_WIDTH)) u_obuf (
        .clk_i     (in_clk),
        .rst_ni    (in_rst_n),
        .s_data_i  (word_q),
        .s_last_i  (word_last_q),
        .s_valid_i (word_vld_q),
        .m_data_o  (out_data),
        .m_last_o  (out_last),
        .m_valid_o (out_valid),
        .m_ready_i (in_ready),
        .full_o    (buf_full),
        .empty_o   (buf_empty)
    );

    assign out_state    = state_q;
    assign out_overflow = overflow_q;
    assign out_drop_cnt = drop_q;
    assign out_frames   = frames_q;

endmodule

// File: tb/tb_daq_capture_packer.sv
module tb_daq_capture_packer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [19:0] in_data = '0;
    logic        in_data_valid = 1'b0, in_pattern_en = 1'b0;
    logic [15:0] in_decim = 16'd1, in_capture_len = '0;
    logic [1:0]  in_trig_mode = '0, in_trig_ch = '0;
    logic [9:0]  in_trig_level = '0;
    logic        arm0 = 1'b0, arm1 = 1'b0, in_trig_sw = 1'b0, in_abort = 1'b0, in_ready = 1'b1;

    logic [31:0] d0, d1;
    logic        v0, v1, l0, l1, of0, of1;
    logic [1:0]  st0, st1;
    logic [15:0] dc0, dc1, fr0, fr1;

    int n_chk = 0, n_err = 0;
    int vcnt = 0;
    int t0;
    logic [32:0] q0[$], q1[$];

    always #5 clk = ~clk;

    daq_capture_packer u_dut0 (
        .in_clk(clk), .in_rst_n(rst_n), .in_data(in_data), .in_data_valid(in_data_valid),
        .in_pattern_en(in_pattern_en), .in_decim(in_decim), .in_capture_len(in_capture_len),
        .in_trig_mode(in_trig_mode), .in_trig_ch(in_trig_ch), .in_trig_level(in_trig_level),
        .in_arm(arm0), .in_trig_sw(in_trig_sw), .in_abort(in_abort),
        .out_data(d0), .out_valid(v0), .in_ready(in_ready), .out_last(l0), .out_state(st0),
        .out_overflow(of0), .out_drop_cnt(dc0), .out_frames(fr0));

    daq_capture_packer #(.INT_CHANNELS(1)) u_dut1 (
        .in_clk(clk), .in_rst_n(rst_n), .in_data(in_data[9:0]), .in_data_valid(in_data_valid),
        .in_pattern_en(in_pattern_en), .in_decim(in_decim), .in_capture_len(in_capture_len),
        .in_trig_mode(in_trig_mode), .in_trig_ch(in_trig_ch), .in_trig_level(in_trig_level),
        .in_arm(arm1), .in_trig_sw(in_trig_sw), .in_abort(in_abort),
        .out_data(d1), .out_valid(v1), .in_ready(in_ready), .out_last(l1), .out_state(st1),
        .out_overflow(of1), .out_drop_cnt(dc1), .out_frames(fr1));

    // handshakes are collected mid-cycle; inputs only change just after posedge
    always @(negedge clk) begin
        if (rst_n && v0 && in_ready) q0.push_back({l0, d0});
        if (rst_n && v1 && in_ready) q1.push_back({l1, d1});
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) vcnt <= 0;
        else if (in_data_valid) vcnt <= vcnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic frame(input logic [9:0] c0, input logic [9:0] c1);
        in_data       = {c1, c0};
        in_data_valid = 1'b1;
        cyc(1);
    endtask

    task automatic wait_idle(input bit which, input string tag);
        int n = 0;
        while (((which ? st1 : st0) != 2'd0) && n < 60) begin
            cyc(1);
            n++;
        end
        chk(tag, which ? st1 : st0, 2'd0);
    endtask

    task automatic chkq(input string tag, input bit which, input int i, input logic [32:0] exp);
        logic [32:0] w;
        w = 33'h1_DEAD_BEEF;
        if (!which && i < q0.size()) w = q0[i];
        if (which && i < q1.size()) w = q1[i];
        chk(tag, w, exp);
    endtask

    function automatic logic [15:0] sx(input int v);
        logic [9:0] s;
        s = v[9:0];
        return {{6{s[9]}}, s};
    endfunction

    function automatic logic [32:0] pw(input bit last, input int t);
        return {last, sx(t + 1), sx(t)};
    endfunction

    initial begin
        // reset
        cyc(2);
        chk("rst_state", st0, 0);
        chk("rst_valid", v0, 0);
        chk("rst_data", d0, 0);
        chk("rst_status", {of0, dc0, fr0, l0}, 0);
        rst_n = 1'b1;
        cyc(2);
        chk("rst_rel_state", {st0, st1, v0, v1}, 0);

        // 1: pattern, immediate, len 4, F=1
        in_pattern_en = 1'b1; in_trig_mode = 2'b10; in_capture_len = 16'd4; in_decim = 16'd1;
        arm0 = 1'b1;
        cyc(1);
        arm0 = 1'b0;
        chk("t1_armed", st0, 2'd1);
        in_data_valid = 1'b1;
        wait_idle(0, "t1_idle");
        in_data_valid = 1'b0;
        chk("t1_nwords", q0.size(), 4);
        chkq("t1_w0", 0, 0, 33'h0_0001_0000);
        chkq("t1_w1", 0, 1, 33'h0_0002_0001);
        chkq("t1_w2", 0, 2, 33'h0_0003_0002);
        chkq("t1_w3", 0, 3, 33'h1_0004_0003);
        chk("t1_frames", fr0, 4);
        q0.delete();

        // 2: one channel, F=2, software trigger, len 3 -> half-filled last word
        in_pattern_en = 1'b0; in_trig_mode = 2'b00; in_capture_len = 16'd3;
        arm1 = 1'b1;
        cyc(1);
        arm1 = 1'b0;
        frame(10'h005, 10'h0);
        in_trig_sw = 1'b1;
        frame(10'h3FF, 10'h0);
        in_trig_sw = 1'b0;
        frame(10'h123, 10'h0);
        in_data_valid = 1'b0;
        wait_idle(1, "t2_idle");
        chk("t2_nwords", q1.size(), 2);
        chkq("t2_w0", 1, 0, 33'h0_FFFF_0005);
        chkq("t2_w1", 1, 1, 33'h1_0000_0123);
        chk("t2_frames", fr1, 3);
        q1.delete();

        // 3: level trigger on ch1 at 100
        in_trig_mode = 2'b01; in_trig_ch = 2'd1; in_trig_level = 10'd100; in_capture_len = 16'd1;
        for (int v = 90; v <= 110; v += 5) frame(10'd7, 10'(v));
        in_data_valid = 1'b0;
        cyc(2);
        chk("t3_idle_notrig", st0, 2'd0);
        arm0 = 1'b1;
        cyc(1);
        arm0 = 1'b0;
        frame(10'd7, 10'd110);
        frame(10'd7, 10'd90);
        frame(10'd7, 10'd95);
        chk("t3_restart_notrig", st0, 2'd1);
        frame(10'd7, 10'd100);
        in_data_valid = 1'b0;
        wait_idle(0, "t3_idle");
        chk("t3_nwords", q0.size(), 1);
        chkq("t3_w0", 0, 0, 33'h1_0064_0007);
        q0.delete();

        // 4: decimation by 4, pattern
        in_pattern_en = 1'b1; in_trig_mode = 2'b10; in_capture_len = 16'd3; in_decim = 16'd4;
        arm0 = 1'b1;
        cyc(1);
        arm0 = 1'b0;
        t0 = vcnt;
        in_data_valid = 1'b1;
        wait_idle(0, "t4_idle");
        in_data_valid = 1'b0;
        chk("t4_nwords", q0.size(), 3);
        chkq("t4_w0", 0, 0, pw(0, t0));
        chkq("t4_w1", 0, 1, pw(0, t0 + 4));
        chkq("t4_w2", 0, 2, pw(1, t0 + 8));
        q0.delete();

        // 5: continuous, downstream stalled -> 2 buffered, 3 dropped
        in_pattern_en = 1'b0; in_capture_len = 16'd0; in_decim = 16'd1; in_ready = 1'b0;
        arm0 = 1'b1;
        cyc(1);
        arm0 = 1'b0;
        for (int k = 1; k <= 5; k++) frame(10'(k), 10'h20);
        in_data_valid = 1'b0;
        cyc(3);
        chk("t5_overflow", of0, 1);
        chk("t5_drops", dc0, 3);
        chk("t5_frames", fr0, 5);
        chk("t5_hold0", {v0, d0}, 33'h1_0020_0001);
        cyc(2);
        chk("t5_hold1", {v0, l0, d0}, 34'h2_0020_0001);
        in_ready = 1'b1;
        cyc(3);
        chk("t5_nwords", q0.size(), 2);
        chkq("t5_w0", 0, 0, 33'h0_0020_0001);
        chkq("t5_w1", 0, 1, 33'h0_0020_0002);
        chk("t5_cap", st0, 2'd2);
        in_abort = 1'b1;
        cyc(1);
        in_abort = 1'b0;
        chk("t5_abort_idle", st0, 2'd0);
        q0.delete();

        // 6: abort with a half-packed word, then async reset mid-word
        in_trig_mode = 2'b10;
        arm1 = 1'b1;
        cyc(1);
        arm1 = 1'b0;
        frame(10'h055, 10'h0);
        in_data_valid = 1'b0;
        cyc(2);
        chk("t6_partial", {st1, fr1}, {2'd2, 16'd1});
        in_abort = 1'b1;
        cyc(1);
        in_abort = 1'b0;
        chk("t6_abort_idle", st1, 2'd0);
        cyc(4);
        chk("t6_no_words", q1.size() + q0.size(), 0);
        arm1 = 1'b1;
        cyc(1);
        arm1 = 1'b0;
        frame(10'h066, 10'h0);
        in_data_valid = 1'b0;
        cyc(2);
        chk("t6_pre_rst", {st1, of0, dc0}, {2'd2, 1'b1, 16'd3});
        rst_n = 1'b0;
        #2;
        chk("t6_rst_dut1", {st1, fr1, v1}, 0);
        chk("t6_rst_dut0", {of0, dc0, fr0, v0, st0}, 0);
        cyc(2);
        rst_n = 1'b1;
        cyc(2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
